// File: rtl/rbm_visible_recon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rbm_visible_recon_pkg
// Description : Shared constants, FSM encodings and the sigmoid transfer
//               function for the RBM visible-layer reconstruction block.
//               Contents:
//                 - default widths, dimensions, LFSR seed and taps
//                 - state_t type and the four FSM state encodings
//                 - sigmoid(): signed 12-bit input with 4 fraction bits in,
//                   unsigned 8-bit probability (x/256) out
// Revision    : 1.0 - initial release
// ============================================================================
package rbm_visible_recon_pkg;

    // Default configuration
    localparam int             c_input_bitlength  = 12;
    localparam int             c_sg_bitlength     = 8;
    localparam int             c_output_bitlength = 12;
    localparam int             c_in_dim           = 6;
    localparam int             c_out_dim          = 5;
    localparam logic [7:0]     c_seed             = 8'hA5;

    // Right-shifting Galois mask for x^8 + x^6 + x^5 + x^4 + 1 (maximal length)
    localparam logic [7:0]     c_lfsr_taps        = 8'hB8;

    // FSM encodings
    typedef logic [1:0] state_t;
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_acc    = 2'd1;
    localparam logic [1:0] c_st_sample = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    // Piecewise-linear sigmoid (PLAN segments). The input carries 4 fraction
    // bits, so |x| breakpoints 1.0 / 2.375 / 5.0 sit at 16 / 38 / 80. The
    // positive-side value y is formed in 1/256 units with a 9-bit range so that
    // y = 256 (saturated) maps to 255 for x > 0 and to exactly 0 for x < 0.
    function automatic logic [c_sg_bitlength-1:0] sigmoid(
        input logic signed [c_input_bitlength-1:0] x
    );
        logic [c_input_bitlength-1:0] mag;
        logic [8:0]                   y;
        // Negating the most negative code yields 0x800, read unsigned as 2048.
        mag = x[c_input_bitlength-1] ? (~x + 1'b1) : x;
        if (mag >= 12'd80) begin
            y = 9'd256;
        end else if (mag >= 12'd38) begin
            y = 9'(mag >> 1) + 9'd216;
        end else if (mag >= 12'd16) begin
            y = 9'(mag << 1) + 9'd160;
        end else begin
            y = 9'(mag << 2) + 9'd128;
        end
        if (x[c_input_bitlength-1]) begin
            sigmoid = 8'(9'd256 - y);
        end else begin
            sigmoid = y[8] ? 8'hFF : y[7:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/rbm_visible_recon_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : rbm_visible_recon_lfsr
// Description : Galois LFSR used as the sampling random source. Loads SEED on
//               reset and advances one step per cycle with step_i high.
//               Ports:
//                 clk_i   clock (rising edge)
//                 rst_i   synchronous active-high reset, reloads SEED
//                 step_i  advance enable
//                 rnd_o   current state, never zero for a nonzero SEED
// Revision    : 1.0 - initial release
// ============================================================================
module rbm_visible_recon_lfsr #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = 8'hA5,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] rnd_o
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (step_i) begin
            state_d = {1'b0, state_q[WIDTH-1:1]} ^ (state_q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign rnd_o = state_q;

endmodule
`default_nettype wire

// File: rtl/rbm_visible_recon.sv
`default_nettype none
// ============================================================================
// Module      : rbm_visible_recon
// Description : Hidden->visible reconstruction of an RBM Gibbs step. For each
//               visible unit j accumulates sum_i h[i]*W[j][i] one term per
//               cycle (saturating), adds b_v[j], applies the sigmoid and samples
//               the probability against an LFSR to give a binary visible unit.
//               Ports:
//                 clock, reset       clock / synchronous active-high reset
//                 start              run request, accepted in IDLE or DONE
//                 HiddenI            binary hidden vector
//                 WeightI            W[j][i] at (j*OUT_DIM+i)*INPUT_BITLENGTH
//                 VBiasI             visible biases b_v[j]
//                 busy, done         run in progress / one-cycle completion
//                 VprobO, VoutputO   per-unit probability / sampled 0-1 value
// Revision    : 1.0 - initial release
// ============================================================================
module rbm_visible_recon
    import rbm_visible_recon_pkg::*;
#(
    parameter int                      INPUT_BITLENGTH  = c_input_bitlength,
    parameter int                      SG_BITLENGTH     = c_sg_bitlength,
    parameter int                      OUTPUT_BITLENGTH = c_output_bitlength,
    parameter int                      IN_DIM           = c_in_dim,
    parameter int                      OUT_DIM          = c_out_dim,
    parameter logic [SG_BITLENGTH-1:0] SEED             = c_seed
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [OUT_DIM-1:0]                    HiddenI,
    input  logic [IN_DIM*OUT_DIM*INPUT_BITLENGTH-1:0] WeightI,
    input  logic [IN_DIM*INPUT_BITLENGTH-1:0]     VBiasI,
    output logic                                  busy,
    output logic                                  done,
    output logic [IN_DIM*SG_BITLENGTH-1:0]        VprobO,
    output logic [IN_DIM*OUTPUT_BITLENGTH-1:0]    VoutputO
);

    localparam int JW = (IN_DIM  > 1) ? $clog2(IN_DIM)  : 1;
    localparam int IW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam logic [JW-1:0] c_j_last = JW'(IN_DIM - 1);
    localparam logic [IW-1:0] c_i_last = IW'(OUT_DIM - 1);

    // Saturating two's-complement add: overflow is detected when the extra
    // sign bit disagrees with the result's sign bit.
    function automatic logic signed [INPUT_BITLENGTH-1:0] sat_add(
        input logic signed [INPUT_BITLENGTH-1:0] a,
        input logic signed [INPUT_BITLENGTH-1:0] b
    );
        logic [INPUT_BITLENGTH:0] s;
        s = {a[INPUT_BITLENGTH-1], a} + {b[INPUT_BITLENGTH-1], b};
        if (s[INPUT_BITLENGTH] != s[INPUT_BITLENGTH-1]) begin
            sat_add = s[INPUT_BITLENGTH] ? {1'b1, {(INPUT_BITLENGTH-1){1'b0}}}
                                         : {1'b0, {(INPUT_BITLENGTH-1){1'b1}}};
        end else begin
            sat_add = s[INPUT_BITLENGTH-1:0];
        end
    endfunction

    // Unpacked views of the packed buses
    logic signed [INPUT_BITLENGTH-1:0] w_weight  [IN_DIM][OUT_DIM];
    logic signed [INPUT_BITLENGTH-1:0] w_bias_in [IN_DIM];

    // State
    state_t                            state_q, state_d;
    logic signed [INPUT_BITLENGTH-1:0] acc_q, acc_d;
    logic [JW-1:0]                     j_q, j_d;
    logic [IW-1:0]                     i_q, i_d;
    logic                              busy_q, busy_d;
    logic                              done_q, done_d;
    logic [OUT_DIM-1:0]                hidden_q;
    logic signed [INPUT_BITLENGTH-1:0] bias_q  [IN_DIM];
    logic [SG_BITLENGTH-1:0]           vprob_q [IN_DIM];
    logic [IN_DIM-1:0]                 vout_q;

    logic                              w_load;
    logic                              w_sample;
    logic signed [INPUT_BITLENGTH-1:0] w_addend;
    logic signed [INPUT_BITLENGTH-1:0] w_sum;
    logic [SG_BITLENGTH-1:0]           w_prob;
    logic [SG_BITLENGTH-1:0]           w_rnd;

    for (genvar gj = 0; gj < IN_DIM; gj++) begin : g_row
        assign w_bias_in[gj] = VBiasI[gj*INPUT_BITLENGTH +: INPUT_BITLENGTH];
        assign VprobO[gj*SG_BITLENGTH +: SG_BITLENGTH] = vprob_q[gj];
        assign VoutputO[gj*OUTPUT_BITLENGTH +: OUTPUT_BITLENGTH] = OUTPUT_BITLENGTH'(vout_q[gj]);
        for (genvar gi = 0; gi < OUT_DIM; gi++) begin : g_col
            assign w_weight[gj][gi] =
                WeightI[(gj*OUT_DIM + gi)*INPUT_BITLENGTH +: INPUT_BITLENGTH];
        end
    end

    // W is read transposed: row j is the visible unit, column i the hidden one.
    assign w_addend = hidden_q[i_q] ? w_weight[j_q][i_q] : '0;
    assign w_sum    = sat_add(acc_q, bias_q[j_q]);
    assign w_prob   = sigmoid(w_sum);

    rbm_visible_recon_lfsr #(
        .WIDTH (SG_BITLENGTH),
        .SEED  (SEED),
        .TAPS  (SG_BITLENGTH'(c_lfsr_taps))
    ) u_lfsr (
        .clk_i  (clock),
        .rst_i  (reset),
        .step_i (w_sample),
        .rnd_o  (w_rnd)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        j_d      = j_q;
        i_d      = i_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        w_load   = 1'b0;
        w_sample = 1'b0;
        case (state_q)
            // A start held across DONE chains straight into the next run so
            // back-to-back runs complete every IN_DIM*(OUT_DIM+1)+1 cycles.
            c_st_idle, c_st_done: begin
                state_d = c_st_idle;
                if (start) begin
                    state_d = c_st_acc;
                    w_load  = 1'b1;
                    acc_d   = '0;
                    j_d     = '0;
                    i_d     = '0;
                    busy_d  = 1'b1;
                end
            end
            c_st_acc: begin
                acc_d = sat_add(acc_q, w_addend);
                if (i_q == c_i_last) begin
                    state_d = c_st_sample;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            c_st_sample: begin
                w_sample = 1'b1;
                acc_d    = '0;
                i_d      = '0;
                if (j_q == c_j_last) begin
                    state_d = c_st_done;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    j_d     = j_q + 1'b1;
                    state_d = c_st_acc;
                end
            end
            default: begin
                state_d = c_st_idle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= c_st_idle;
            acc_q    <= '0;
            j_q      <= '0;
            i_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hidden_q <= '0;
            vout_q   <= '0;
            for (int k = 0; k < IN_DIM; k++) begin
                bias_q[k]  <= '0;
                vprob_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            j_q     <= j_d;
            i_q     <= i_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (w_load) begin
                hidden_q <= HiddenI;
                bias_q   <= w_bias_in;
            end
            if (w_sample) begin
                vprob_q[j_q] <= w_prob;
                vout_q[j_q]  <= (w_prob > w_rnd);
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_rbm_visible_recon.sv
`default_nettype none
// ============================================================================
// Module      : tb_rbm_visible_recon
// Description : Self-checking bench for rbm_visible_recon. Expected results
//               are queued when a run is launched and compared when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rbm_visible_recon;

    localparam int         IB = 12;
    localparam int         SG = 8;
    localparam int         OB = 12;
    localparam int         ND = 6;
    localparam int         NH = 5;
    localparam logic [7:0] SEED_V = 8'hA5;

    logic                clock = 1'b0;
    logic                reset;
    logic                start;
    logic [NH-1:0]       HiddenI;
    logic [ND*NH*IB-1:0] WeightI;
    logic [ND*IB-1:0]    VBiasI;
    logic                busy;
    logic                done;
    logic [ND*SG-1:0]    VprobO;
    logic [ND*OB-1:0]    VoutputO;

    always #5 clock = ~clock;

    rbm_visible_recon #(
        .INPUT_BITLENGTH  (IB),
        .SG_BITLENGTH     (SG),
        .OUTPUT_BITLENGTH (OB),
        .IN_DIM           (ND),
        .OUT_DIM          (NH),
        .SEED             (SEED_V)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .HiddenI  (HiddenI),
        .WeightI  (WeightI),
        .VBiasI   (VBiasI),
        .busy     (busy),
        .done     (done),
        .VprobO   (VprobO),
        .VoutputO (VoutputO)
    );

    typedef struct packed {
        logic [ND*SG-1:0] prob;
        logic [ND*OB-1:0] vout;
    } exp_t;

    exp_t       sb_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] m_lfsr;

    // ---------------- reference model ----------------
    function automatic int ref_sat(input int v);
        if (v > 2047)  return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    function automatic int ref_sigmoid(input int s);
        real x;
        real y;
        int  q;
        x = ((s < 0) ? -s : s) / 16.0;
        if (x >= 5.0)        y = 1.0;
        else if (x >= 2.375) y = 0.03125 * x + 0.84375;
        else if (x >= 1.0)   y = 0.125 * x + 0.625;
        else                 y = 0.25 * x + 0.5;
        q = int'($floor(y * 256.0));
        if (s < 0)         q = 256 - q;
        else if (q > 255)  q = 255;
        return q;
    endfunction

    function automatic exp_t model(input logic [NH-1:0] h,
                                   input logic [ND*NH*IB-1:0] w,
                                   input logic [ND*IB-1:0] b);
        exp_t        e;
        int          acc;
        int          s;
        int          p;
        logic [IB-1:0] el;
        e = '0;
        for (int j = 0; j < ND; j++) begin
            acc = 0;
            for (int i = 0; i < NH; i++) begin
                if (h[i]) begin
                    el  = w[(j*NH + i)*IB +: IB];
                    acc = ref_sat(acc + int'($signed(el)));
                end
            end
            el = b[j*IB +: IB];
            s  = ref_sat(acc + int'($signed(el)));
            p  = ref_sigmoid(s);
            e.prob[j*SG +: SG] = 8'(p);
            e.vout[j*OB +: OB] = (p > int'(m_lfsr)) ? 12'd1 : 12'd0;
            m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
        end
        return e;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: done=1 with no run outstanding at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                n_vec++;
                if (VprobO !== e.prob) begin
                    n_err++;
                    $display("FAIL vprob: got %h expected %h", VprobO, e.prob);
                end
                n_vec++;
                if (VoutputO !== e.vout) begin
                    n_err++;
                    $display("FAIL voutput: got %h expected %h", VoutputO, e.vout);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic launch(input logic [NH-1:0] h, input logic [ND*NH*IB-1:0] w,
                          input logic [ND*IB-1:0] b);
        @(negedge clock);
        HiddenI = h;
        WeightI = w;
        VBiasI  = b;
        sb_q.push_back(model(h, w, b));
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Counts negedges until done is seen (bounded).
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (done !== 1'b1 && cyc < 200);
    endtask

    function automatic logic [ND*NH*IB-1:0] rand_weights(input int span);
        logic [ND*NH*IB-1:0] w;
        for (int k = 0; k < ND*NH; k++)
            w[k*IB +: IB] = 12'($urandom_range(0, 2*span - 1)) - 12'(span);
        return w;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset   = 1'b1;
        start   = 1'b1;
        HiddenI = '1;
        WeightI = '0;
        VBiasI  = '0;
        repeat (3) begin
            @(negedge clock);
            n_vec++;
            if (busy !== 1'b0 || done !== 1'b0 || VprobO !== '0 || VoutputO !== '0) begin
                n_err++;
                $display("FAIL reset_state: busy=%b done=%b prob=%h vout=%h expected all zero",
                         busy, done, VprobO, VoutputO);
            end
        end
        start  = 1'b0;
        reset  = 1'b0;
        m_lfsr = SEED_V;
        @(negedge clock);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_zero_hidden();
        int cyc;
        launch(5'b0, rand_weights(2048), '0);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after_start: busy=%b expected 1", busy);
        end
        wait_done(cyc);
        n_vec++;
        if (cyc != 36) begin
            n_err++;
            $display("FAIL latency_zero: done after %0d cycles expected 36", cyc);
        end
        @(negedge clock);
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || VprobO !== {ND{8'h80}}) begin
            n_err++;
            $display("FAIL zero_hold: done=%b busy=%b prob=%h expected 0 0 %h",
                     done, busy, VprobO, {ND{8'h80}});
        end
    endtask

    task automatic test_saturation();
        int cyc;
        launch(5'b11111, {ND*NH{12'h7FF}}, {ND{12'h7FF}});
        wait_done(cyc);
        n_vec++;
        if (VprobO !== {ND{8'hFF}}) begin
            n_err++;
            $display("FAIL sat_max: prob=%h expected %h", VprobO, {ND{8'hFF}});
        end
        launch(5'b11111, {ND*NH{12'h800}}, {ND{12'h800}});
        wait_done(cyc);
        n_vec++;
        if (VprobO !== '0 || VoutputO !== '0) begin
            n_err++;
            $display("FAIL sat_min: prob=%h vout=%h expected 0 0", VprobO, VoutputO);
        end
    endtask

    task automatic test_transpose();
        int                  cyc;
        logic [ND*NH*IB-1:0] w;
        for (int j = 0; j < ND; j++)
            for (int i = 0; i < NH; i++)
                w[(j*NH + i)*IB +: IB] = (i == 2) ? 12'(16*j) : 12'h3FF;
        launch(5'b00100, w, '0);
        wait_done(cyc);
        n_vec++;
        if (VprobO !== {8'd255, 8'd248, 8'd240, 8'd224, 8'd192, 8'd128}) begin
            n_err++;
            $display("FAIL transpose: prob=%h expected %h", VprobO,
                     {8'd255, 8'd248, 8'd240, 8'd224, 8'd192, 8'd128});
        end
    endtask

    task automatic test_random();
        int               cyc;
        logic [ND*IB-1:0] b;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < ND; j++) b[j*IB +: IB] = 12'($urandom_range(0, 63)) - 12'd32;
            launch(NH'($urandom_range(0, 31)), rand_weights(40), b);
            wait_done(cyc);
            n_vec++;
            if (cyc != 36) begin
                n_err++;
                $display("FAIL latency_random%0d: done after %0d cycles expected 36", r, cyc);
            end
        end
    endtask

    task automatic test_back_to_back();
        int                  first;
        int                  ndone;
        int                  cyc;
        logic [ND*NH*IB-1:0] w;
        w = rand_weights(48);
        launch(5'b10110, w, '0);
        first = 0;
        ndone = 0;
        for (int c = 1; c <= 60; c++) begin
            start = (c == 5 || c == 20);
            @(negedge clock);
            if (done === 1'b1) begin
                ndone++;
                if (first == 0) first = c;
            end
        end
        start = 1'b0;
        n_vec++;
        if (ndone != 1 || first != 36) begin
            n_err++;
            $display("FAIL start_ignored: %0d done pulses first at %0d expected 1 at 36", ndone, first);
        end
        // start held high across two runs
        @(negedge clock);
        HiddenI = 5'b01011;
        sb_q.push_back(model(HiddenI, WeightI, VBiasI));
        sb_q.push_back(model(HiddenI, WeightI, VBiasI));
        start = 1'b1;
        wait_done(cyc);
        n_vec++;
        if (cyc != 37) begin
            n_err++;
            $display("FAIL held_first: done after %0d cycles expected 37", cyc);
        end
        wait_done(cyc);
        start = 1'b0;
        n_vec++;
        if (cyc != 37) begin
            n_err++;
            $display("FAIL held_gap: second done %0d cycles after first expected 37", cyc);
        end
    endtask

    task automatic test_reset_abort();
        int                  cyc;
        bit                  seen;
        logic [ND*NH*IB-1:0] w;
        w = rand_weights(2048);
        launch(5'b0, w, '0);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || VprobO !== '0 || VoutputO !== '0) begin
            n_err++;
            $display("FAIL abort_state: busy=%b done=%b prob=%h vout=%h expected all zero",
                     busy, done, VprobO, VoutputO);
        end
        reset = 1'b0;
        sb_q.delete();
        m_lfsr = SEED_V;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL abort_no_done: done=1 seen after abort expected none");
        end
        launch(5'b0, w, '0);
        wait_done(cyc);
        n_vec++;
        if (cyc != 36) begin
            n_err++;
            $display("FAIL latency_after_abort: done after %0d cycles expected 36", cyc);
        end
    endtask

    initial begin
        test_reset();
        test_zero_hidden();
        test_saturation();
        test_transpose();
        test_random();
        test_back_to_back();
        test_reset_abort();
        repeat (3) @(negedge clock);
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d results outstanding expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
